// File: rtl/sd_host_pkg.sv
// Shared types, protocol constants and CRC helpers for the SD SPI host engine.
package sd_host_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_R1,
        ST_R1,
        ST_WAIT_TOK,
        ST_RD_SHIFT,
        ST_WR_GAP,
        ST_WR_SHIFT,
        ST_WAIT_DR,
        ST_DR,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam logic [5:0] CMD_READ     = 6'd17;
    localparam logic [5:0] CMD_WRITE    = 6'd24;
    localparam logic [7:0] START_TOKEN  = 8'hFE;
    localparam logic [7:0] DATA_RESP_OK = 8'b0000_0101;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = c[6] ^ d[39 - i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_ccitt(input logic [63:0] d);
        logic [15:0] c;
        logic        fb;
        c = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            fb = c[15] ^ d[63 - i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_spi_host_if.sv
// Request/response and serial lines between the bridge, the host engine and the card.
interface sd_spi_host_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_rw;
    logic [15:0] in_addr;
    logic [63:0] in_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_err;
    logic        MOSI;
    logic        MISO;

    modport master (
        output in_valid, in_rw, in_addr, in_data, MISO,
        input  in_ready, out_valid, out_data, out_err, MOSI
    );

    modport slave (
        input  in_valid, in_rw, in_addr, in_data, MISO,
        output in_ready, out_valid, out_data, out_err, MOSI
    );
endinterface

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT (poly 0x1021, init 0), one bit per enabled cycle, MSB first.
module sd_crc16_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);
    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (shift_en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_in) ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc_out = crc_q;
endmodule

// File: rtl/sd_spi_host.sv
// SD SPI host engine: one CMD17/CMD24 block transaction per request, with R1,
// token, CRC16, data-response and busy handling plus per-state timeout.
module sd_spi_host
    import sd_host_pkg::*;
#(
    parameter int unsigned WR_IDLE_UNITS = 2,
    parameter int unsigned TIMEOUT_CYC   = 4096
) (
    input  logic           clk,
    input  logic           rst,
    sd_spi_host_if.slave   bus
);
    localparam int unsigned       TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0]        GAP_LAST = 7'(WR_IDLE_UNITS * 8 - 8);

    state_e        state_q, state_d;
    logic          rw_q, rw_d;
    logic [63:0]   data_q, data_d;
    logic [87:0]   tx_q, tx_d;
    logic [78:0]   rx_q, rx_d;
    logic [6:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mosi_q, mosi_d;
    logic          err_q, err_d;
    logic [63:0]   odata_q, odata_d;

    logic          crc_clr, crc_en, crc_bit;
    logic [15:0]   crc_val;
    logic [5:0]    op;
    logic [47:0]   frame;
    logic [79:0]   rx_shift;

    sd_crc16_serial u_crc (
        .clk      (clk),
        .rst      (rst),
        .clear    (crc_clr),
        .shift_en (crc_en),
        .bit_in   (crc_bit),
        .crc_out  (crc_val)
    );

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        data_d   = data_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bcnt_d   = bcnt_q;
        tmo_d    = '0;
        mosi_d   = mosi_q;
        err_d    = err_q;
        odata_d  = odata_q;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        crc_bit  = 1'b0;
        op       = bus.in_rw ? CMD_WRITE : CMD_READ;
        frame    = {2'b01, op, 16'h0000, bus.in_addr,
                    crc7({2'b01, op, 16'h0000, bus.in_addr}), 1'b1};
        rx_shift = {rx_q, bus.MISO};

        unique case (state_q)
            ST_IDLE: if (bus.in_valid) begin
                rw_d    = bus.in_rw;
                data_d  = bus.in_data;
                err_d   = 1'b0;
                crc_clr = 1'b1;
                mosi_d  = frame[47];
                tx_d    = {frame[46:0], {41{1'b1}}};
                bcnt_d  = '0;
                state_d = ST_CMD;
            end
            ST_CMD: begin
                if (bcnt_q == 7'd47) begin
                    mosi_d  = 1'b1;
                    state_d = ST_WAIT_R1;
                end else begin
                    mosi_d = tx_q[87];
                    tx_d   = {tx_q[86:0], 1'b1};
                    bcnt_d = bcnt_q + 7'd1;
                end
            end
            ST_WAIT_R1: begin
                if (!bus.MISO) begin
                    bcnt_d  = 7'd1;
                    state_d = ST_R1;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_R1: begin
                if (bus.MISO) err_d = 1'b1;
                bcnt_d = bcnt_q + 7'd1;
                if (bcnt_q == 7'd7) begin
                    bcnt_d = '0;
                    rx_d   = '0;
                    if (err_d)     state_d = ST_DONE;
                    else if (rw_q) state_d = ST_WR_GAP;
                    else           state_d = ST_WAIT_TOK;
                end
            end
            ST_WAIT_TOK: begin
                rx_d = rx_shift[78:0];
                if (rx_shift[7:0] == START_TOKEN) begin
                    bcnt_d  = '0;
                    state_d = ST_RD_SHIFT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RD_SHIFT: begin
                rx_d    = rx_shift[78:0];
                crc_en  = (bcnt_q < 7'd64);
                crc_bit = bus.MISO;
                bcnt_d  = bcnt_q + 7'd1;
                if (bcnt_q == 7'd79) begin
                    odata_d = rx_shift[79:16];
                    err_d   = (rx_shift[15:0] != crc_val);
                    state_d = ST_DONE;
                end
            end
            ST_WR_GAP: begin
                bcnt_d = bcnt_q + 7'd1;
                if (bcnt_q == GAP_LAST) begin
                    mosi_d  = START_TOKEN[7];
                    tx_d    = {START_TOKEN[6:0], data_q, {17{1'b1}}};
                    bcnt_d  = '0;
                    state_d = ST_WR_SHIFT;
                end
            end
            ST_WR_SHIFT: begin
                // Data bits feed the CRC as they go out; CRC is spliced in right after the last one.
                crc_en  = (bcnt_q >= 7'd7) && (bcnt_q <= 7'd70);
                crc_bit = tx_q[87];
                bcnt_d  = bcnt_q + 7'd1;
                if (bcnt_q == 7'd87) begin
                    mosi_d  = 1'b1;
                    bcnt_d  = '0;
                    state_d = ST_WAIT_DR;
                end else if (bcnt_q == 7'd71) begin
                    mosi_d = crc_val[15];
                    tx_d   = {crc_val[14:0], {73{1'b1}}};
                end else begin
                    mosi_d = tx_q[87];
                    tx_d   = {tx_q[86:0], 1'b1};
                end
            end
            ST_WAIT_DR: begin
                if (!bus.MISO) begin
                    rx_d    = rx_shift[78:0];
                    bcnt_d  = 7'd1;
                    state_d = ST_DR;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DR: begin
                rx_d   = rx_shift[78:0];
                bcnt_d = bcnt_q + 7'd1;
                if (bcnt_q == 7'd7) begin
                    if (rx_shift[7:0] == DATA_RESP_OK) begin
                        state_d = ST_BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.MISO) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Only a completed read data phase returns data; every other completion reports zero.
        if (state_d == ST_DONE && state_q != ST_RD_SHIFT) odata_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            data_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
            mosi_q  <= 1'b1;
            err_q   <= 1'b0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
            mosi_q  <= mosi_d;
            err_q   <= err_d;
            odata_q <= odata_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_err   = (state_q == ST_DONE) & err_q;
    assign bus.out_data  = odata_q;
    assign bus.MOSI      = mosi_q;
endmodule
